// File: rtl/eco32f_div_pkg.sv
// Shared types and constants for the eco32f serial divider sequencer.
package eco32f_div_pkg;

  // Operand width; also the number of restoring iterations per divide.
  localparam int DIV_BITS_DEF = 32;

  // Iteration counter must hold the value DIV_BITS itself.
  localparam int CNT_W = $clog2(DIV_BITS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/eco32f_div_ctrl.sv
// Sequencer for the EX-stage serial divider: accepts div/rem requests,
// drives load/step/fix-up strobes into the datapath, stalls EX while busy,
// signals completion and flags divide-by-zero. A flush aborts any
// in-flight division without producing a result.
module eco32f_div_ctrl
  import eco32f_div_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_valid,
  input  logic ex_op_div,
  input  logic ex_op_rem,
  input  logic ex_signed_div,
  input  logic ex_x_neg,
  input  logic ex_y_neg,
  input  logic ex_y_zero,
  input  logic ex_stall,
  input  logic ex_flush,
  input  logic dp_sub_neg,
  output logic dp_load,
  output logic dp_neg_x,
  output logic dp_neg_y,
  output logic dp_step,
  output logic dp_sub_take,
  output logic dp_fix_q,
  output logic dp_fix_r,
  output logic div_stall,
  output logic div_done,
  output logic div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;  // quotient must be negated at fix-up
  logic             neg_rem_q, neg_rem_d;  // remainder must be negated at fix-up
  logic             start;

  // A div and a rem flag together still form only one request.
  assign start = ex_valid & (ex_op_div | ex_op_rem) & ~ex_flush;

  // State, counter and sign flags; reset returns to an idle, cleared sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Next-state and strobe decode; outputs are Moore except in IDLE, where
  // the request is answered in the same cycle it is presented.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dp_load     = 1'b0;
    dp_neg_x    = 1'b0;
    dp_neg_y    = 1'b0;
    dp_step     = 1'b0;
    dp_sub_take = 1'b0;
    dp_fix_q    = 1'b0;
    dp_fix_r    = 1'b0;
    div_stall   = 1'b0;
    div_done    = 1'b0;
    div_by_zero = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (ex_y_zero) begin
            // Trap immediately; the datapath is never started.
            div_by_zero = 1'b1;
          end else begin
            dp_load   = 1'b1;
            dp_neg_x  = ex_signed_div & ex_x_neg;
            dp_neg_y  = ex_signed_div & ex_y_neg;
            div_stall = 1'b1;
            // Truncating division: quotient sign is the sign product,
            // remainder follows the dividend.
            neg_quo_d = ex_signed_div & (ex_x_neg ^ ex_y_neg);
            neg_rem_d = ex_signed_div & ex_x_neg;
            cnt_d     = CNT_LOAD;
            state_d   = ITER;
          end
        end
      end

      ITER: begin
        if (ex_flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          dp_step     = 1'b1;
          dp_sub_take = ~dp_sub_neg;
          div_stall   = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = FIXUP;
          end
        end
      end

      FIXUP: begin
        if (ex_flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          dp_fix_q  = neg_quo_q;
          dp_fix_r  = neg_rem_q;
          div_stall = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        if (ex_flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Result is held for EX until the rest of the pipeline moves on.
          div_done = 1'b1;
          if (!ex_stall) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eco32f_div_ctrl.sv
// Scoreboard bench for eco32f_div_ctrl: a restoring datapath driven by the
// DUT strobes produces q/r, which are compared with plain SV division.
module tb_eco32f_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 0, ex_op_div = 0, ex_op_rem = 0, ex_signed_div = 0;
  logic ex_x_neg, ex_y_neg, ex_y_zero;
  logic ex_stall = 0, ex_flush = 0;
  logic dp_sub_neg;
  logic dp_load, dp_neg_x, dp_neg_y, dp_step, dp_sub_take, dp_fix_q, dp_fix_r;
  logic div_stall, div_done, div_by_zero;

  logic [31:0] op_x = 0, op_y = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          dz;
    logic [31:0] q;
    logic [31:0] r;
    int          issue;
  } exp_t;
  exp_t sb[$];

  assign ex_x_neg  = op_x[31];
  assign ex_y_neg  = op_y[31];
  assign ex_y_zero = (op_y == 32'd0);

  eco32f_div_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op_div(ex_op_div),
    .ex_op_rem(ex_op_rem), .ex_signed_div(ex_signed_div), .ex_x_neg(ex_x_neg),
    .ex_y_neg(ex_y_neg), .ex_y_zero(ex_y_zero), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .dp_sub_neg(dp_sub_neg), .dp_load(dp_load),
    .dp_neg_x(dp_neg_x), .dp_neg_y(dp_neg_y), .dp_step(dp_step),
    .dp_sub_take(dp_sub_take), .dp_fix_q(dp_fix_q), .dp_fix_r(dp_fix_r),
    .div_stall(div_stall), .div_done(div_done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment datapath: restoring divider reacting to the DUT strobes.
  logic [31:0] dp_rem = 0, dp_quo = 0, dp_dvs = 0;
  logic [32:0] sh;
  logic [33:0] trial;
  assign sh         = {dp_rem, dp_quo[31]};
  assign trial      = {1'b0, sh} - {2'b0, dp_dvs};
  assign dp_sub_neg = trial[33];

  always @(posedge clk) begin
    if (dp_load) begin
      dp_rem <= 32'd0;
      dp_quo <= dp_neg_x ? -op_x : op_x;
      dp_dvs <= dp_neg_y ? -op_y : op_y;
    end else if (dp_step) begin
      dp_rem <= dp_sub_take ? trial[31:0] : sh[31:0];
      dp_quo <= {dp_quo[30:0], dp_sub_take};
    end else begin
      if (dp_fix_q) dp_quo <= -dp_quo;
      if (dp_fix_r) dp_rem <= -dp_rem;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or trap.
  bit prev_done = 0;
  int stall_cnt = 0;
  int step_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 0; stall_cnt = 0; step_cnt = 0;
    end else begin
      chk("sub_take_idle", {31'd0, dp_sub_take & ~dp_step}, 32'd0);
      if (div_by_zero) begin
        if (sb.size() == 0) chk("unexpected_dz", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("dz_kind", {31'd0, e.dz}, 32'd1);
          chk("dz_stall", {31'd0, div_stall}, 32'd0);
        end
      end
      if (dp_load) begin stall_cnt = 0; step_cnt = 0; end
      if (div_stall) stall_cnt++;
      if (dp_step) step_cnt++;
      if (div_done && !prev_done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("done_kind", {31'd0, e.dz}, 32'd0);
          chk("quotient", dp_quo, e.q);
          chk("remainder", dp_rem, e.r);
          chk("latency", 32'(cyc - e.issue), 32'd34);
          chk("stall_cycles", 32'(stall_cnt), 32'd34);
          chk("step_count", 32'(step_cnt), 32'd32);
          chk("done_stall_low", {31'd0, div_stall}, 32'd0);
          $display("div result q=%0h r=%0h issued at %0d", dp_quo, dp_rem, e.issue);
        end
      end
      if (!div_stall && !div_done) begin stall_cnt = 0; step_cnt = 0; end
      prev_done = div_done;
    end
  end

  // Present one request; caller is at posedge+1 of an IDLE cycle.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit sgn,
                       input bit isdiv, input bit push);
    exp_t e;
    bit nz;
    nz = (y != 0);
    op_x = x; op_y = y; ex_signed_div = sgn;
    ex_op_div = isdiv; ex_op_rem = !isdiv; ex_valid = 1'b1;
    #1;
    chk("load", {31'd0, dp_load}, {31'd0, nz});
    chk("neg_x", {31'd0, dp_neg_x}, {31'd0, nz & sgn & x[31]});
    chk("neg_y", {31'd0, dp_neg_y}, {31'd0, nz & sgn & y[31]});
    chk("req_stall", {31'd0, div_stall}, {31'd0, nz});
    chk("req_dz", {31'd0, div_by_zero}, {31'd0, !nz && !ex_flush});
    if (push) begin
      e.dz = !nz; e.issue = cyc; e.q = 0; e.r = 0;
      if (nz) begin
        if (sgn) begin
          e.q = $signed(x) / $signed(y);
          e.r = $signed(x) % $signed(y);
        end else begin
          e.q = x / y;
          e.r = x % y;
        end
      end
      sb.push_back(e);
      $display("issue x=%0h y=%0h signed=%0d div=%0d", x, y, sgn, isdiv);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // Wait for div_done, hold ex_stall for n cycles, then check release to IDLE.
  task automatic wait_done(input int n);
    int t = 0;
    int dc = 0;
    while (!div_done && t < 60) begin
      @(posedge clk); #1; t++;
    end
    if (!div_done) chk("done_timeout", 32'd1, 32'd0);
    for (int i = 0; i <= n; i++) begin
      if (div_done) dc++;
      ex_stall = (i < n);
      @(posedge clk); #1;
    end
    chk("done_cycles", 32'(dc), 32'(n + 1));
    chk("idle_after_done", {31'd0, div_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    bit sgn;
    int dc;
    #3;
    chk("reset_outputs", {22'd0, dp_load, dp_neg_x, dp_neg_y, dp_step, dp_sub_take,
                          dp_fix_q, dp_fix_r, div_stall, div_done, div_by_zero}, 32'd0);
    #20; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases; the last issue directly follows DONE (minimum spacing).
    issue(32'd100, 32'd7, 0, 1, 1); wait_done(0);
    issue(-32'sd100, 32'd7, 1, 1, 1); wait_done(0);
    issue(32'd100, -32'sd7, 1, 0, 1); wait_done(3);
    issue(32'd5, 32'd0, 0, 1, 1);
    issue(32'h8000_0000, 32'd1, 1, 1, 1); wait_done(0);

    // Non-divide instruction: nothing happens.
    op_x = 5; op_y = 0; ex_op_div = 0; ex_op_rem = 0; ex_valid = 1; #1;
    chk("nondiv_quiet", {30'd0, div_by_zero, dp_load}, 32'd0);
    @(posedge clk); #1; ex_valid = 0;

    // Flush in IDLE suppresses a divide-by-zero trap.
    ex_flush = 1; issue(32'd5, 32'd0, 0, 1, 0); ex_flush = 0;

    // Both op flags set: still exactly one request.
    op_x = 50; op_y = 6; ex_signed_div = 0; ex_op_div = 1; ex_op_rem = 1; ex_valid = 1;
    sb.push_back('{dz: 0, q: 32'd8, r: 32'd2, issue: cyc});
    #1; chk("both_ops_load", {31'd0, dp_load}, 32'd1);
    @(posedge clk); #1; ex_valid = 0; ex_op_rem = 0;
    wait_done(0);

    // Flush at T10 of ITER, new request accepted at T12.
    issue(32'd1000, 32'd3, 0, 1, 0);
    repeat (9) begin @(posedge clk); #1; end
    ex_flush = 1; #1;
    chk("flush_no_step", {30'd0, dp_step, div_done}, 32'd0);
    @(posedge clk); #1; ex_flush = 0;
    chk("post_flush_quiet", {30'd0, dp_step, div_stall}, 32'd0);
    @(posedge clk); #1;
    issue(32'd77, 32'd10, 0, 1, 1); wait_done(1);

    // Async reset mid-ITER clears outputs at once; no result follows.
    issue(32'd12345, 32'd17, 0, 1, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1; #1;
    chk("rst_mid_outputs", {22'd0, dp_load, dp_neg_x, dp_neg_y, dp_step, dp_sub_take,
                            dp_fix_q, dp_fix_r, div_stall, div_done, div_by_zero}, 32'd0);
    @(posedge clk); #1; rst = 0;
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (div_done) dc++; end
    chk("rst_no_done", 32'(dc), 32'd0);

    // Randomized requests.
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      if ($urandom_range(0, 1) == 1) x = $urandom_range(0, 1000) - 500;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1, 2: y = $urandom_range(1, 40) - 20;
        default: y = $urandom;
      endcase
      sgn = $urandom_range(0, 1) == 1;
      if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
      issue(x, y, sgn, $urandom_range(0, 1) == 1, 1);
      if (y != 0) wait_done($urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/eco32f_div_ctrl.md
# eco32f_div_ctrl

Sequencer for the EX-stage serial divider of the eco32f pipeline. It accepts div/rem requests from EX and drives the divider datapath's load/step/fix-up strobes for one restoring iteration per quotient bit. It raises the EX stall, signals completion and reports divide-by-zero. It also handles aborting an in-flight division on a pipeline flush.

## Interface
- DIV_BITS, 32: operand width, equal to the number of iterations.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  first cycle of a new instruction in EX
- ex_op_div  in  1  EX instruction is div/divu
- ex_op_rem  in  1  EX instruction is rem/remu
- ex_signed_div  in  1  signed variant
- ex_x_neg  in  1  dividend bit 31
- ex_y_neg  in  1  divisor bit 31
- ex_y_zero  in  1  divisor == 0
- ex_stall  in  1  EX held by another source (MEM stall etc.)
- ex_flush  in  1  pipeline flush (exception/branch); aborts
- dp_sub_neg  in  1  datapath trial subtraction result is negative
- dp_load  out  1  load operands, clear remainder
- dp_neg_x  out  1  with dp_load: two's-complement the dividend
- dp_neg_y  out  1  with dp_load: two's-complement the divisor
- dp_step  out  1  perform one shift/subtract iteration
- dp_sub_take  out  1  with dp_step: keep difference, shift in quotient 1
- dp_fix_q  out  1  negate the quotient register
- dp_fix_r  out  1  negate the remainder register
- div_stall  out  1  stall request to the pipeline
- div_done  out  1  quotient/remainder valid for EX result mux
- div_by_zero  out  1  one-cycle exception pulse

## Operation
- start = ex_valid & (ex_op_div | ex_op_rem) & !ex_flush, evaluated in IDLE only.
- States: IDLE, ITER, FIXUP, DONE. 6-bit counter cnt.
- IDLE, start & ex_y_zero: div_by_zero=1 for that cycle; no load, no stall; stay IDLE.
- IDLE, start & !ex_y_zero: dp_load=1, dp_neg_x=ex_signed_div&ex_x_neg, dp_neg_y=ex_signed_div&ex_y_neg. Registers neg_q=signed&(x_neg^y_neg) and neg_r=signed&x_neg. cnt<=DIV_BITS, next state ITER, div_stall=1.
- ITER: dp_step=1, dp_sub_take=!dp_sub_neg, cnt<=cnt-1; cnt==1 -> FIXUP. div_stall=1.
- FIXUP: dp_fix_q=neg_q, dp_fix_r=neg_r. The remainder takes the dividend's sign (truncating division). Next state DONE; div_stall=1.
- DONE: div_done=1, div_stall=0. Stay while ex_stall=1; leave for IDLE when ex_stall=0.
- ex_flush in ITER/FIXUP/DONE: all dp_* outputs forced 0 that cycle, next state IDLE, cnt<=0, div_done never asserted.
- ex_flush in IDLE: start suppressed, including div_by_zero.
- Non-div ops in IDLE: all outputs 0.
- In IDLE, ex_valid with both ex_op_div and ex_op_rem set is illegal; it is treated as a single request.

## Timing
- Reset: state IDLE, cnt 0, neg_q/neg_r 0, all outputs 0.
- Reset asserted mid-division returns to IDLE immediately. No done or exception pulse follows.
- Outputs are Moore, except in IDLE: dp_load, dp_neg_*, div_stall and div_by_zero there are combinational from the ex_* inputs.
- Latency for a nonzero divisor:
  - T0 load, stall.
  - T1..T32 step, stall.
  - T33 fixup, stall.
  - T34 div_done, stall low.
  - div_stall is high for exactly DIV_BITS+2 cycles.
- Divide-by-zero: 0 stall cycles; div_by_zero in the request cycle.
- Back-to-back divides: the next request is accepted in the first IDLE cycle after DONE. Minimum spacing is DIV_BITS+3 cycles.
- dp_sub_take is only meaningful while dp_step=1 and is 0 otherwise.

## Structure
- Package eco32f_div_pkg holds:
  - the state enum (IDLE, ITER, FIXUP, DONE) with 2-bit encoding;
  - the DIV_BITS default;
  - the counter width constant CNT_W = $clog2(DIV_BITS+1).
- Single module. No sub-module: the counter and FSM are a single process pair.
- The datapath (n, d, r registers, subtractor) stays in eco32f_alu, which is driven by the dp_* strobes.

## Test plan
- Unsigned 100/7: ex_valid, ex_op_div, signed=0 → dp_load at T0, 32 dp_step pulses, dp_fix_q=dp_fix_r=0 at T33, div_done at T34. A reference datapath gives q=14, r=2.
- Signed -100/7: dp_neg_x=1, dp_neg_y=0, FIXUP asserts dp_fix_q=1 and dp_fix_r=1. Result q=-14, r=-2.
- Signed 100/-7: dp_neg_y=1 at load; FIXUP dp_fix_q=1, dp_fix_r=0 → q=-14, r=2.
- Divide by zero (x=5, y=0, div): div_by_zero pulse in the request cycle, div_stall=0, no dp_load, state stays IDLE.
- Flush at T10 of ITER: no dp_step after T10, div_done never asserted, next request at T12 accepted with dp_load=1.
- ex_stall held 3 cycles at DONE: div_done high for 4 cycles, then IDLE. An async rst pulse during ITER clears all outputs in the same cycle.
